// File: rtl/bat_register_bank_if.sv
// Bus, ALU-operand and control bundle for bat_register_bank.
// master = controller/bus side, slave = the register bank.
interface bat_register_bank_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
);
  logic             WR_EN;
  logic [SEL_W-1:0] WR_SEL;
  logic [WIDTH-1:0] BUS_IN;
  logic             RD_EN;
  logic [SEL_W-1:0] RD_SEL;
  logic [WIDTH-1:0] BUS_OUT;
  logic             BUS_DRIVE;
  logic             CNT_EN;
  logic [SEL_W-1:0] CNT_SEL;
  logic             CNT_DIR;
  logic [SEL_W-1:0] A_SEL;
  logic [SEL_W-1:0] B_SEL;
  logic [WIDTH-1:0] A_OUT;
  logic [WIDTH-1:0] B_OUT;
  logic [WIDTH-1:0] OUT;
  logic             OUT_STROBE;
  logic             CNT_WRAP;
  logic             CONFLICT;
  logic             SEL_ERR;
  logic             CLR_ERR;

  modport master (
    output WR_EN, WR_SEL, BUS_IN, RD_EN, RD_SEL, CNT_EN, CNT_SEL, CNT_DIR,
           A_SEL, B_SEL, CLR_ERR,
    input  BUS_OUT, BUS_DRIVE, A_OUT, B_OUT, OUT, OUT_STROBE, CNT_WRAP,
           CONFLICT, SEL_ERR
  );

  modport slave (
    input  WR_EN, WR_SEL, BUS_IN, RD_EN, RD_SEL, CNT_EN, CNT_SEL, CNT_DIR,
           A_SEL, B_SEL, CLR_ERR,
    output BUS_OUT, BUS_DRIVE, A_OUT, B_OUT, OUT, OUT_STROBE, CNT_WRAP,
           CONFLICT, SEL_ERR
  );
endinterface

// File: rtl/bat_register_bank.sv
// Parametrised register bank: one bus write port, one bus read port, two ALU
// operand ports, per-register up/down counting with wrap pulse, OUT mirror
// with write strobe, and sticky conflict / select-error flags.
module bat_register_bank #(
  parameter int                 WIDTH     = 16,
  parameter int                 NUM_REGS  = 8,
  parameter int                 SEL_W     = 3,
  parameter int                 OUT_IDX   = 7,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  bat_register_bank_if.slave    bus
);

  // One extra bit so NUM_REGS == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic             wr_in, cnt_in, rd_in;
  logic             wr_ok, cnt_ok, conflict_now, sel_err_now;
  logic [WIDTH-1:0] a_val, b_val, rd_val, cnt_cur;
  logic             strobe_q, wrap_q, conflict_q, sel_err_q;

  assign wr_in  = {1'b0, bus.WR_SEL}  < NREGS;
  assign cnt_in = {1'b0, bus.CNT_SEL} < NREGS;
  assign rd_in  = {1'b0, bus.RD_SEL}  < NREGS;

  assign wr_ok        = bus.WR_EN  & wr_in;
  assign cnt_ok       = bus.CNT_EN & cnt_in;
  assign conflict_now = wr_ok & cnt_ok & (bus.WR_SEL == bus.CNT_SEL);
  // Operand selects are free-running and never flag an error.
  assign sel_err_now  = (bus.WR_EN  & ~wr_in) |
                        (bus.CNT_EN & ~cnt_in) |
                        (bus.RD_EN  & ~rd_in);

  // Read muxes; an out-of-range select yields 0.
  always_comb begin
    a_val   = '0;
    b_val   = '0;
    rd_val  = '0;
    cnt_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.A_SEL   == SEL_W'(i)) a_val   = regs[i];
      if (bus.B_SEL   == SEL_W'(i)) b_val   = regs[i];
      if (bus.RD_SEL  == SEL_W'(i)) rd_val  = regs[i];
      if (bus.CNT_SEL == SEL_W'(i)) cnt_cur = regs[i];
    end
  end

  // Register update: write beats count on the same target; flags and pulses.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      strobe_q   <= 1'b0;
      wrap_q     <= 1'b0;
      conflict_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && bus.WR_SEL == SEL_W'(i))
          regs[i] <= bus.BUS_IN;
        else if (cnt_ok && bus.CNT_SEL == SEL_W'(i))
          regs[i] <= bus.CNT_DIR ? regs[i] - 1'b1 : regs[i] + 1'b1;
      end
      strobe_q   <= wr_ok && (bus.WR_SEL == SEL_W'(OUT_IDX));
      wrap_q     <= cnt_ok && !conflict_now &&
                    (bus.CNT_DIR ? (cnt_cur == '0) : (cnt_cur == '1));
      // A new error in the clearing edge still leaves the flag set.
      conflict_q <= conflict_now | (conflict_q & ~bus.CLR_ERR);
      sel_err_q  <= sel_err_now  | (sel_err_q  & ~bus.CLR_ERR);
    end
  end

  assign bus.A_OUT      = a_val;
  assign bus.B_OUT      = b_val;
  assign bus.BUS_DRIVE  = bus.RD_EN & rd_in;
  assign bus.BUS_OUT    = bus.BUS_DRIVE ? rd_val : '0;
  assign bus.OUT        = regs[OUT_IDX];
  assign bus.OUT_STROBE = strobe_q;
  assign bus.CNT_WRAP   = wrap_q;
  assign bus.CONFLICT   = conflict_q;
  assign bus.SEL_ERR    = sel_err_q;

endmodule

// File: tb/tb_bat_register_bank.sv
// Directed bench for bat_register_bank: default 8-register bank (ua) and a
// 6-register bank (ub) for out-of-range select behaviour.
module tb_bat_register_bank;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 CLOCK = ~CLOCK;

  bat_register_bank_if #(.WIDTH(16), .SEL_W(3)) ia ();
  bat_register_bank_if #(.WIDTH(16), .SEL_W(3)) ib ();

  bat_register_bank #(.WIDTH(16), .NUM_REGS(8), .SEL_W(3), .OUT_IDX(7))
    ua (.CLOCK(CLOCK), .RESET(RESET), .bus(ia));
  bat_register_bank #(.WIDTH(16), .NUM_REGS(6), .SEL_W(3), .OUT_IDX(5))
    ub (.CLOCK(CLOCK), .RESET(RESET), .bus(ib));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_a();
    ia.WR_EN = 0; ia.WR_SEL = 0; ia.BUS_IN = 0; ia.RD_EN = 0; ia.RD_SEL = 0;
    ia.CNT_EN = 0; ia.CNT_SEL = 0; ia.CNT_DIR = 0; ia.A_SEL = 0; ia.B_SEL = 0;
    ia.CLR_ERR = 0;
  endtask

  task automatic idle_b();
    ib.WR_EN = 0; ib.WR_SEL = 0; ib.BUS_IN = 0; ib.RD_EN = 0; ib.RD_SEL = 0;
    ib.CNT_EN = 0; ib.CNT_SEL = 0; ib.CNT_DIR = 0; ib.A_SEL = 0; ib.B_SEL = 0;
    ib.CLR_ERR = 0;
  endtask

  initial begin
    idle_a(); idle_b();
    RESET = 1; tick(); tick(); RESET = 0;

    // Reset state
    ia.A_SEL = 3; ia.B_SEL = 7; #1;
    chk("rst_a_out", ia.A_OUT, 16'h0000);
    chk("rst_b_out", ia.B_OUT, 16'h0000);
    chk("rst_drive", ia.BUS_DRIVE, 1'b0);
    chk("rst_flags", {ia.OUT_STROBE, ia.CNT_WRAP, ia.CONFLICT, ia.SEL_ERR}, 16'h0);

    // 1: write then read on bus and operand port
    ia.WR_EN = 1; ia.WR_SEL = 3; ia.BUS_IN = 16'hBEEF; tick();
    idle_a(); ia.RD_EN = 1; ia.RD_SEL = 3; ia.A_SEL = 3; #1;
    chk("t1_bus_out", ia.BUS_OUT, 16'hBEEF);
    chk("t1_drive",   ia.BUS_DRIVE, 1'b1);
    chk("t1_a_out",   ia.A_OUT, 16'hBEEF);
    // Read and write of the same register: old value until the edge
    ia.WR_EN = 1; ia.WR_SEL = 3; ia.BUS_IN = 16'h1111; #1;
    chk("t1_rw_old", ia.BUS_OUT, 16'hBEEF);
    tick(); ia.WR_EN = 0; #1;
    chk("t1_rw_new", ia.BUS_OUT, 16'h1111);

    // 2: count wrap both directions
    idle_a(); ia.WR_EN = 1; ia.WR_SEL = 2; ia.BUS_IN = 16'hFFFF; tick();
    idle_a(); ia.B_SEL = 2; ia.CNT_EN = 1; ia.CNT_SEL = 2; ia.CNT_DIR = 0; tick();
    chk("t2_up_val",  ia.B_OUT, 16'h0000);
    chk("t2_up_wrap", ia.CNT_WRAP, 1'b1);
    ia.CNT_EN = 0; tick();
    chk("t2_wrap_clr", ia.CNT_WRAP, 1'b0);
    ia.CNT_EN = 1; ia.CNT_DIR = 1; tick();
    chk("t2_dn_val",  ia.B_OUT, 16'hFFFF);
    chk("t2_dn_wrap", ia.CNT_WRAP, 1'b1);
    tick();
    chk("t2_dn2_val",  ia.B_OUT, 16'hFFFE);
    chk("t2_dn2_wrap", ia.CNT_WRAP, 1'b0);

    // 3: write and count on same register
    idle_a(); ia.WR_EN = 1; ia.WR_SEL = 5; ia.BUS_IN = 16'h1234;
    ia.CNT_EN = 1; ia.CNT_SEL = 5; tick();
    idle_a(); ia.A_SEL = 5; #1;
    chk("t3_val",      ia.A_OUT, 16'h1234);
    chk("t3_conflict", ia.CONFLICT, 1'b1);
    chk("t3_nowrap",   ia.CNT_WRAP, 1'b0);
    tick();
    chk("t3_sticky", ia.CONFLICT, 1'b1);
    ia.CLR_ERR = 1; tick(); ia.CLR_ERR = 0;
    chk("t3_cleared", ia.CONFLICT, 1'b0);

    // 4: write and count on different registers
    ia.WR_EN = 1; ia.WR_SEL = 4; ia.BUS_IN = 16'h0009; tick();
    ia.WR_SEL = 1; ia.BUS_IN = 16'h0010; ia.CNT_EN = 1; ia.CNT_SEL = 4; ia.CNT_DIR = 0;
    tick();
    idle_a(); ia.A_SEL = 1; ia.B_SEL = 4; #1;
    chk("t4_r1", ia.A_OUT, 16'h0010);
    chk("t4_r4", ia.B_OUT, 16'h000A);
    chk("t4_noconf", ia.CONFLICT, 1'b0);

    // 5: OUT mirror and strobe
    ia.WR_EN = 1; ia.WR_SEL = 7; ia.BUS_IN = 16'h00AA; tick(); ia.WR_EN = 0;
    chk("t5_out",    ia.OUT, 16'h00AA);
    chk("t5_strobe", ia.OUT_STROBE, 1'b1);
    tick();
    chk("t5_strobe_once", ia.OUT_STROBE, 1'b0);
    ia.CNT_EN = 1; ia.CNT_SEL = 7; ia.CNT_DIR = 0; tick(); ia.CNT_EN = 0;
    chk("t5_cnt_out",   ia.OUT, 16'h00AB);
    chk("t5_cnt_nostb", ia.OUT_STROBE, 1'b0);
    // Unchanged-value write still strobes
    ia.WR_EN = 1; ia.WR_SEL = 7; ia.BUS_IN = 16'h00AB; tick(); ia.WR_EN = 0;
    chk("t5_same_stb", ia.OUT_STROBE, 1'b1);
    // Clear in the same edge as a new conflict: flag stays set
    ia.WR_EN = 1; ia.WR_SEL = 7; ia.BUS_IN = 16'h0055; ia.CNT_EN = 1; ia.CNT_SEL = 7;
    ia.CLR_ERR = 1; tick(); idle_a();
    chk("t5_clr_vs_new", ia.CONFLICT, 1'b1);
    chk("t5_conf_out",   ia.OUT, 16'h0055);

    // 6: 6-register bank, out-of-range selects
    ib.WR_EN = 1; ib.WR_SEL = 5; ib.BUS_IN = 16'h5555; tick(); idle_b();
    ib.A_SEL = 6; tick();
    chk("t6_a_oor",     ib.A_OUT, 16'h0000);
    chk("t6_a_noerr",   ib.SEL_ERR, 1'b0);
    ib.WR_EN = 1; ib.WR_SEL = 6; ib.BUS_IN = 16'hFFFF; tick(); idle_b();
    chk("t6_wr_err",   ib.SEL_ERR, 1'b1);
    chk("t6_r5_keep",  ib.OUT, 16'h5555);
    ib.A_SEL = 0; #1;
    chk("t6_r0_keep",  ib.A_OUT, 16'h0000);
    ib.CLR_ERR = 1; tick(); ib.CLR_ERR = 0;
    chk("t6_err_clr",  ib.SEL_ERR, 1'b0);
    ib.RD_EN = 1; ib.RD_SEL = 7; #1;
    chk("t6_rd_drive", ib.BUS_DRIVE, 1'b0);
    chk("t6_rd_out",   ib.BUS_OUT, 16'h0000);
    tick(); ib.RD_EN = 0;
    chk("t6_rd_err",   ib.SEL_ERR, 1'b1);
    // Reset mid-count and mid-write
    ib.CNT_EN = 1; ib.CNT_SEL = 5; ib.WR_EN = 1; ib.WR_SEL = 0; ib.BUS_IN = 16'h7777;
    ia.CNT_EN = 1; ia.CNT_SEL = 7;
    RESET = 1; tick(); RESET = 0; idle_b(); idle_a();
    chk("t6_rst_out",   ib.OUT, 16'h0000);
    chk("t6_rst_r0",    ib.A_OUT, 16'h0000);
    chk("t6_rst_flags", {ib.OUT_STROBE, ib.CNT_WRAP, ib.CONFLICT, ib.SEL_ERR}, 16'h0);
    chk("t6_rst_a_out", ia.OUT, 16'h0000);
    chk("t6_rst_a_conf", ia.CONFLICT, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
